ooo_read_responder: RTL and testbench



---
 rtl/ooo_resp_pkg.sv | 21 ++
 rtl/ooo_read_responder_lfsr8.sv | 20 ++
 rtl/ooo_read_responder.sv | 182 ++++++++++++++++++
 tb/tb_ooo_read_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ooo_resp_pkg.sv
// Shared definitions for the out-of-order read responder: return-order modes
// and the pseudo-random generator constants.
package ooo_resp_pkg;

    typedef enum logic [1:0] {
        ORDER_OLDEST     = 2'd0,
        ORDER_YOUNGEST   = 2'd1,
        ORDER_RANDOM     = 2'd2,
        ORDER_OLDEST_ALT = 2'd3
    } order_mode_e;

    localparam int LFSR_WIDTH = 8;
    // x^8 + x^6 + x^5 + x^4 + 1, feedback taken from bits 7,5,4,3
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 8'h01;

    function automatic logic lfsr_feedback(input logic [LFSR_WIDTH-1:0] state);
        return ^(state & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/ooo_read_responder_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to pick the scan start for
// pseudo-random return order.
module lfsr8
    import ooo_resp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    output logic [LFSR_WIDTH-1:0] state
);

    // Shift register advancing every cycle; a maximal polynomial keeps it nonzero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LFSR_SEED;
        end else begin
            state <= {state[LFSR_WIDTH-2:0], lfsr_feedback(state)};
        end
    end

endmodule

// File: rtl/ooo_read_responder.sv
// Read responder that holds up to DEPTH outstanding requests and returns them
// oldest-first, youngest-first or pseudo-randomly, keeping same-ID order.
module ooo_read_responder
    import ooo_resp_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 4,
    parameter int DEPTH      = 4,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_arid_i,
    input  logic                  s_arvalid_i,
    output logic                  s_arready_o,
    output logic [DATA_WIDTH-1:0] s_rdata_o,
    output logic [ID_WIDTH-1:0]   s_rid_o,
    output logic                  s_rvalid_o,
    input  logic                  s_rready_i,
    input  logic [1:0]            order_mode_i
);

    localparam int SEQ_WIDTH   = DATA_WIDTH - ID_WIDTH;
    localparam int TIMER_WIDTH = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam int IDX_WIDTH   = (DEPTH < 2) ? 1 : $clog2(DEPTH);

    logic [DEPTH-1:0]       valid_r;
    logic [ID_WIDTH-1:0]    id_r    [DEPTH];
    logic [SEQ_WIDTH-1:0]   seq_r   [DEPTH];
    logic [TIMER_WIDTH-1:0] timer_r [DEPTH];
    // older_r[i][j] set means slot i was issued before slot j; only meaningful when both are valid
    logic [DEPTH-1:0]       older_r [DEPTH];
    logic [SEQ_WIDTH-1:0]   issue_cnt_r;
    logic                   arready_r;
    logic                   rvalid_r;
    logic [ID_WIDTH-1:0]    rid_r;
    logic [DATA_WIDTH-1:0]  rdata_r;

    logic [LFSR_WIDTH-1:0]  lfsr_s;
    order_mode_e            mode_s;
    logic                   ar_hs_s;
    logic                   load_s;
    logic                   pick_valid_s;
    logic [IDX_WIDTH-1:0]   alloc_idx_s;
    logic [IDX_WIDTH-1:0]   pick_idx_s;
    logic [DEPTH-1:0]       elig_s;
    logic [DEPTH-1:0]       has_older_elig_s;
    logic [DEPTH-1:0]       valid_next_s;

    lfsr8 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr_s)
    );

    assign mode_s  = order_mode_e'(order_mode_i);
    assign ar_hs_s = s_arvalid_i && arready_r;
    assign load_s  = !rvalid_r || s_rready_i;

    // Eligibility: timer expired and no older valid slot carries the same ID
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            elig_s[i] = valid_r[i] && (timer_r[i] == '0);
            for (int j = 0; j < DEPTH; j++) begin
                elig_s[i] = elig_s[i] && !((j != i) && valid_r[j] && older_r[j][i]
                                           && (id_r[j] == id_r[i]));
            end
        end
    end

    // Age relations among eligible slots, plus lowest free slot for allocation
    always_comb begin
        alloc_idx_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            has_older_elig_s[i] = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                has_older_elig_s[i] = has_older_elig_s[i] || (elig_s[j] && older_r[j][i]);
            end
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            alloc_idx_s = valid_r[i] ? alloc_idx_s : IDX_WIDTH'(i);
        end
    end

    // Return-order selection among eligible slots
    always_comb begin
        int start;
        int idx;
        pick_valid_s = |elig_s;
        pick_idx_s   = '0;
        start        = int'(lfsr_s) % DEPTH;
        idx          = 0;
        case (mode_s)
            ORDER_YOUNGEST: begin
                for (int i = 0; i < DEPTH; i++) begin
                    pick_idx_s = (elig_s[i] && !(|(older_r[i] & elig_s))) ? IDX_WIDTH'(i) : pick_idx_s;
                end
            end
            ORDER_RANDOM: begin
                // walk downward so the first eligible slot at or after start wins
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    idx        = (start + k) % DEPTH;
                    pick_idx_s = elig_s[idx] ? IDX_WIDTH'(idx) : pick_idx_s;
                end
            end
            default: begin
                for (int i = 0; i < DEPTH; i++) begin
                    pick_idx_s = (elig_s[i] && !has_older_elig_s[i]) ? IDX_WIDTH'(i) : pick_idx_s;
                end
            end
        endcase
    end

    // Occupancy after this edge, used to register the request-ready flag
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_next_s[i] = (valid_r[i] && !(load_s && pick_valid_s && (pick_idx_s == IDX_WIDTH'(i))))
                              || (ar_hs_s && (alloc_idx_s == IDX_WIDTH'(i)));
        end
    end

    // Slot table: allocate on request, count down timers, free on load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r     <= '0;
            issue_cnt_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                id_r[i]    <= '0;
                seq_r[i]   <= '0;
                timer_r[i] <= '0;
                older_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_r[i] && (timer_r[i] != '0)) begin
                    timer_r[i] <= timer_r[i] - TIMER_WIDTH'(1);
                end
            end
            if (load_s && pick_valid_s) begin
                valid_r[pick_idx_s] <= 1'b0;
            end
            if (ar_hs_s) begin
                valid_r[alloc_idx_s] <= 1'b1;
                id_r[alloc_idx_s]    <= s_arid_i;
                seq_r[alloc_idx_s]   <= issue_cnt_r;
                timer_r[alloc_idx_s] <= TIMER_WIDTH'(LATENCY);
                older_r[alloc_idx_s] <= '0;
                for (int j = 0; j < DEPTH; j++) begin
                    if (j != int'(alloc_idx_s)) begin
                        older_r[j][alloc_idx_s] <= valid_r[j];
                    end
                end
                issue_cnt_r <= issue_cnt_r + SEQ_WIDTH'(1);
            end
        end
    end

    // Registered handshake outputs; a held beat is frozen until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rid_r     <= '0;
            rdata_r   <= '0;
        end else begin
            arready_r <= ~&valid_next_s;
            if (load_s) begin
                rvalid_r <= pick_valid_s;
                if (pick_valid_s) begin
                    rid_r   <= id_r[pick_idx_s];
                    rdata_r <= {id_r[pick_idx_s], seq_r[pick_idx_s]};
                end
            end
        end
    end

    assign s_arready_o = arready_r;
    assign s_rvalid_o  = rvalid_r;
    assign s_rid_o     = rid_r;
    assign s_rdata_o   = rdata_r;

endmodule

// File: tb/tb_ooo_read_responder.sv
// Directed bench for ooo_read_responder: ordering modes, same-ID ordering,
// backpressure hold, reset discard and sequence wrap.
module tb_ooo_read_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] arid;
    logic       arvalid;
    logic       arready;
    logic [7:0] rdata;
    logic [3:0] rid;
    logic       rvalid;
    logic       rready;
    logic [1:0] mode;

    always #5 clk = ~clk;

    ooo_read_responder #(
        .DATA_WIDTH (8),
        .ID_WIDTH   (4),
        .DEPTH      (4),
        .LATENCY    (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_arid_i     (arid),
        .s_arvalid_i  (arvalid),
        .s_arready_o  (arready),
        .s_rdata_o    (rdata),
        .s_rid_o      (rid),
        .s_rvalid_o   (rvalid),
        .s_rready_i   (rready),
        .order_mode_i (mode)
    );

    int          checks_total  = 0;
    int          checks_passed = 0;
    logic [11:0] got_q[$];
    logic [11:0] exp_q[$];
    int          cyc          = 0;
    int          first_rv_cyc = -1;
    int          last_ar_cyc  = -1;
    bit          toggle_rready = 1'b0;
    bit          rand_rready   = 1'b0;
    bit          held_prev     = 1'b0;
    logic [11:0] held_beat;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        if (obs === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // One cycle: finalise inputs, record handshakes at the coming edge, move to next negedge
    task automatic advance();
        if (toggle_rready) rready = ~rready;
        else if (rand_rready) rready = 1'($urandom_range(0, 1));
        if (held_prev) begin
            check_value("hold_valid", {31'd0, rvalid}, 32'd1);
            check_value("hold_beat", {20'd0, rid, rdata}, {20'd0, held_beat});
        end
        held_prev = rvalid && !rready;
        held_beat = {rid, rdata};
        if (rvalid && rready) got_q.push_back({rid, rdata});
        if (rvalid && first_rv_cyc < 0) first_rv_cyc = cyc;
        if (arvalid && arready) last_ar_cyc = cyc;
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input bit check_outputs);
        rst = 1'b1;
        arvalid = 1'b0;
        rready = 1'b0;
        toggle_rready = 1'b0;
        rand_rready = 1'b0;
        held_prev = 1'b0;
        #1;
        if (check_outputs) begin
            check_value("rst_arready", {31'd0, arready}, 32'd0);
            check_value("rst_rvalid", {31'd0, rvalid}, 32'd0);
            check_value("rst_rid", {28'd0, rid}, 32'd0);
            check_value("rst_rdata", {24'd0, rdata}, 32'd0);
        end
        advance();
        advance();
        rst = 1'b0;
        advance();
        if (check_outputs) begin
            check_value("rst_arready_rise", {31'd0, arready}, 32'd1);
            check_value("rst_rvalid_low", {31'd0, rvalid}, 32'd0);
        end
        got_q.delete();
        exp_q.delete();
        first_rv_cyc = -1;
    endtask

    task automatic send_ar(input logic [3:0] id);
        bit acc;
        acc = 1'b0;
        arvalid = 1'b1;
        arid = id;
        for (int n = 0; n < 40 && !acc; n++) begin
            acc = arready;
            advance();
        end
        arvalid = 1'b0;
        check_value("ar_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic wait_beats(input string tag, input int n, input int budget);
        for (int k = 0; k < budget && got_q.size() < n; k++) advance();
        check_value({tag, "_count"}, got_q.size(), n);
    endtask

    task automatic compare_beats(input string tag);
        for (int k = 0; k < exp_q.size(); k++) begin
            check_value($sformatf("%s_beat%0d", tag, k),
                        (k < got_q.size()) ? {20'd0, got_q[k]} : 32'hFFFF_FFFF,
                        {20'd0, exp_q[k]});
        end
    endtask

    initial begin
        rst = 1'b0;
        arid = 4'd0;
        arvalid = 1'b0;
        rready = 1'b0;
        mode = 2'd0;
        #2;
        rst = 1'b1;
        @(negedge clk);

        // reset state and ready rise after release
        do_reset(1'b1);

        // oldest-first, latency and data format
        mode = 2'd0;
        rready = 1'b1;
        send_ar(4'd4);
        begin
            int a_cyc;
            a_cyc = last_ar_cyc;
            send_ar(4'd7);
            send_ar(4'd0);
            wait_beats("t1", 3, 20);
            check_value("t1_latency", first_rv_cyc - a_cyc - 1, 32'd3);
        end
        exp_q = '{12'h440, 12'h771, 12'h002};
        compare_beats("t1");

        // youngest-first under backpressure; first beat loads while the table fills
        do_reset(1'b0);
        mode = 2'd1;
        rready = 1'b0;
        send_ar(4'd1);
        send_ar(4'd2);
        send_ar(4'd3);
        send_ar(4'd12);
        send_ar(4'd10);
        check_value("t2_full_arready", {31'd0, arready}, 32'd0);
        mode = 2'd0;
        repeat (4) advance();
        check_value("t2_held_rid", {28'd0, rid}, 32'd1);
        mode = 2'd1;
        rready = 1'b1;
        wait_beats("t2", 5, 20);
        exp_q = '{12'h110, 12'hAA4, 12'hCC3, 12'h332, 12'h221};
        compare_beats("t2");

        // same ID keeps request order even in youngest-first mode
        do_reset(1'b0);
        mode = 2'd1;
        rready = 1'b0;
        send_ar(4'd5);
        send_ar(4'd5);
        send_ar(4'd5);
        repeat (5) advance();
        rready = 1'b1;
        wait_beats("t3", 3, 20);
        exp_q = '{12'h550, 12'h551, 12'h552};
        compare_beats("t3");

        // pseudo-random order with rready toggling every cycle
        do_reset(1'b0);
        mode = 2'd2;
        toggle_rready = 1'b1;
        send_ar(4'd3);
        send_ar(4'd6);
        send_ar(4'd9);
        send_ar(4'd14);
        wait_beats("t4", 4, 40);
        repeat (6) advance();
        toggle_rready = 1'b0;
        check_value("t4_total", got_q.size(), 32'd4);
        exp_q = '{12'h330, 12'h661, 12'h992, 12'hEE3};
        foreach (exp_q[e]) begin
            int hits;
            hits = 0;
            foreach (got_q[g]) if (got_q[g] == exp_q[e]) hits++;
            check_value($sformatf("t4_once%0d", e), hits, 32'd1);
        end

        // reset with a full table and a held beat
        do_reset(1'b0);
        mode = 2'd0;
        rready = 1'b0;
        for (int i = 1; i <= 5; i++) send_ar(4'(i));
        check_value("t5_rvalid_before", {31'd0, rvalid}, 32'd1);
        check_value("t5_arready_before", {31'd0, arready}, 32'd0);
        rst = 1'b1;
        held_prev = 1'b0;
        #1;
        check_value("t5_rst_arready", {31'd0, arready}, 32'd0);
        check_value("t5_rst_rvalid", {31'd0, rvalid}, 32'd0);
        check_value("t5_rst_rid", {28'd0, rid}, 32'd0);
        check_value("t5_rst_rdata", {24'd0, rdata}, 32'd0);
        advance();
        advance();
        rst = 1'b0;
        rready = 1'b1;
        got_q.delete();
        repeat (6) advance();
        check_value("t5_no_stale", got_q.size(), 32'd0);
        send_ar(4'd9);
        wait_beats("t5", 1, 20);
        exp_q = '{12'h990};
        compare_beats("t5");

        // twenty requests with random rready: sequence wraps, order stays oldest-first
        do_reset(1'b0);
        mode = 2'd0;
        rand_rready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [3:0] id;
            logic [3:0] seq;
            id = 4'($urandom_range(0, 15));
            seq = 4'(i);
            send_ar(id);
            exp_q.push_back({id, id, seq});
        end
        wait_beats("t6", 20, 300);
        rand_rready = 1'b0;
        compare_beats("t6");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
